// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select, halt retirement and retire counter.
// Latency: one i_step edge from MEM-stage inputs to WB outputs; o_wb_data is combinational from the latch.
// No backpressure: i_step=0 holds the register and masks the write strobe; HALTED freezes everything until reset.
module mem_wb_stage #(
   parameter int NB     = 32,
   parameter int NB_REG = 5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_step,
   input  logic              i_valid,
   input  logic [NB-1:0]     i_data_memory,
   input  logic [NB-1:0]     i_alu_result,
   input  logic [NB-1:0]     i_pc_link,
   input  logic [NB_REG-1:0] i_rd_addr,
   input  logic              i_reg_write,
   input  logic              i_mem_to_reg,
   input  logic              i_link,
   input  logic              i_halt,
   output logic [NB-1:0]     o_wb_data,
   output logic [NB_REG-1:0] o_wb_addr,
   output logic              o_wb_enable,
   output logic              o_valid,
   output logic              o_halt,
   output logic [NB-1:0]     o_retired
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t state, state_nxt;
   logic   latch_en;

   logic              valid_q;
   logic [NB-1:0]     data_memory_q;
   logic [NB-1:0]     alu_result_q;
   logic [NB-1:0]     pc_link_q;
   logic [NB_REG-1:0] rd_addr_q;
   logic              reg_write_q;
   logic              mem_to_reg_q;
   logic              link_q;
   logic              halt_q;
   logic              step_d;
   logic [NB-1:0]     retired_q;

   localparam logic [NB-1:0] RETIRED_MAX = {NB{1'b1}};
   localparam logic [NB-1:0] RETIRED_ONE = {{(NB-1){1'b0}}, 1'b1};

   // State register: reset returns to RUN from anywhere, including HALTED.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and latch enable: only a step in RUN moves the pipeline; a retiring valid HALT freezes it.
   always_comb begin
      state_nxt = state;
      latch_en  = 1'b0;
      if (state == RUN) begin
         latch_en = i_step;
         if (i_step && i_valid && i_halt) begin
            state_nxt = HALTED;
         end
      end
   end

   // WB register and retire counter; bubbles latch with their control bits cleared so they can never write.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         valid_q       <= 1'b0;
         data_memory_q <= '0;
         alu_result_q  <= '0;
         pc_link_q     <= '0;
         rd_addr_q     <= '0;
         reg_write_q   <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         link_q        <= 1'b0;
         halt_q        <= 1'b0;
         step_d        <= 1'b0;
         retired_q     <= '0;
      end else begin
         step_d <= latch_en;
         if (latch_en) begin
            valid_q       <= i_valid;
            data_memory_q <= i_data_memory;
            alu_result_q  <= i_alu_result;
            pc_link_q     <= i_pc_link;
            rd_addr_q     <= i_rd_addr;
            reg_write_q   <= i_valid & i_reg_write;
            mem_to_reg_q  <= i_valid & i_mem_to_reg;
            link_q        <= i_valid & i_link;
            halt_q        <= i_valid & i_halt;
            if (i_valid && (retired_q != RETIRED_MAX)) begin
               retired_q <= retired_q + RETIRED_ONE;
            end
         end
      end
   end

   // Write-back select: link beats load beats ALU.
   always_comb begin
      if (link_q) begin
         o_wb_data = pc_link_q;
      end else if (mem_to_reg_q) begin
         o_wb_data = data_memory_q;
      end else begin
         o_wb_data = alu_result_q;
      end
   end

   // step_d limits the strobe to the single cycle after the latching step, so a stalled instruction writes once.
   assign o_wb_enable = valid_q & reg_write_q & (rd_addr_q != '0) & ~halt_q & step_d;
   assign o_wb_addr   = rd_addr_q;
   assign o_valid     = valid_q;
   assign o_halt      = (state == HALTED);
   assign o_retired   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
   localparam int NB     = 32;
   localparam int NB_REG = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              step = 1'b0;
   logic              valid = 1'b0;
   logic [NB-1:0]     dmem = '0;
   logic [NB-1:0]     alu = '0;
   logic [NB-1:0]     pcl = '0;
   logic [NB_REG-1:0] rd = '0;
   logic              rw = 1'b0;
   logic              m2r = 1'b0;
   logic              lnk = 1'b0;
   logic              hlt = 1'b0;

   logic [NB-1:0]     wb_data;
   logic [NB_REG-1:0] wb_addr;
   logic              wb_en;
   logic              o_valid;
   logic              o_halt;
   logic [NB-1:0]     retired;

   int errors = 0;
   int checks = 0;

   // Reference model: the instruction currently sitting in WB and its expected effects.
   logic              m_valid = 1'b0;
   logic [NB_REG-1:0] m_rd = '0;
   logic [NB-1:0]     m_data = '0;
   logic              m_we = 1'b0;
   logic [NB-1:0]     m_ret = '0;
   logic              m_halted = 1'b0;

   mem_wb_stage #(.NB(NB), .NB_REG(NB_REG)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_step(step), .i_valid(valid),
      .i_data_memory(dmem), .i_alu_result(alu), .i_pc_link(pcl), .i_rd_addr(rd),
      .i_reg_write(rw), .i_mem_to_reg(m2r), .i_link(lnk), .i_halt(hlt),
      .o_wb_data(wb_data), .o_wb_addr(wb_addr), .o_wb_enable(wb_en),
      .o_valid(o_valid), .o_halt(o_halt), .o_retired(retired)
   );

   always #5 clk = ~clk;

   // One rising edge: the model consumes the same inputs the DUT samples, then outputs settle.
   task automatic edge_step();
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 0; m_rd = '0; m_data = '0; m_we = 0; m_ret = '0; m_halted = 0;
      end else if (m_halted) begin
         m_we = 0;
      end else if (step) begin
         m_valid = valid;
         m_rd    = rd;
         m_data  = lnk ? pcl : (m2r ? dmem : alu);
         m_we    = valid && rw && (rd != 0) && !hlt;
         if (valid && m_ret != {NB{1'b1}}) m_ret = m_ret + 1;
         if (valid && hlt) m_halted = 1;
      end else begin
         m_we = 0;
      end
      #1;
   endtask

   task automatic set_instr(input logic v, input logic w, input logic [NB_REG-1:0] r,
                            input logic [NB-1:0] a, input logic [NB-1:0] d, input logic [NB-1:0] p,
                            input logic mr, input logic l, input logic h);
      valid = v; rw = w; rd = r; alu = a; dmem = d; pcl = p; m2r = mr; lnk = l; hlt = h;
   endtask

   task automatic do_reset();
      rst_n = 0; step = 0;
      edge_step();
      rst_n = 1;
   endtask

   task automatic test_reset();
      set_instr(1, 1, 5'd9, 32'hAAAA, 32'hBBBB, 32'hCCCC, 0, 0, 0);
      rst_n = 0; step = 1;
      edge_step();
      rst_n = 1; step = 0;
      checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", wb_data); end
      checks++; if (wb_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", wb_addr); end
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", wb_en); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", o_halt); end
      checks++; if (retired !== '0) begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
   endtask

   task automatic test_alu_write();
      set_instr(1, 1, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 0);
      step = 1;
      edge_step();
      step = 0;
      checks++; if (wb_addr !== 5'd5) begin errors++; $display("FAIL alu_addr: got %0d want 5", wb_addr); end
      checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL alu_data: got %h want 00001234", wb_data); end
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL alu_en: got %b want 1", wb_en); end
      checks++; if (retired !== 32'd1) begin errors++; $display("FAIL alu_retired: got %0d want 1", retired); end
      edge_step();
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL alu_en_once: got %b want 0", wb_en); end
   endtask

   task automatic test_priority();
      set_instr(1, 1, 5'd6, 32'h10, 32'hFFFFFF80, 32'h48, 1, 0, 0);
      step = 1; edge_step(); step = 0;
      checks++; if (wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL load_data: got %h want ffffff80", wb_data); end
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL load_en: got %b want 1", wb_en); end
      set_instr(1, 1, 5'd31, 32'h10, 32'hFFFFFF80, 32'h48, 1, 1, 0);
      step = 1; edge_step(); step = 0;
      checks++; if (wb_data !== 32'h48) begin errors++; $display("FAIL link_data: got %h want 00000048", wb_data); end
      checks++; if (wb_addr !== 5'd31) begin errors++; $display("FAIL link_addr: got %0d want 31", wb_addr); end
   endtask

   task automatic test_zero_bubble();
      logic [NB-1:0] r0;
      r0 = retired;
      set_instr(1, 1, 5'd0, 32'h55, 32'h0, 32'h0, 0, 0, 0);
      step = 1; edge_step(); step = 0;
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL zero_en: got %b want 0", wb_en); end
      checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL zero_addr: got %0d want 0", wb_addr); end
      checks++; if (retired !== r0 + 1) begin errors++; $display("FAIL zero_retired: got %0d want %0d", retired, r0 + 1); end
      set_instr(0, 1, 5'd7, 32'h66, 32'h0, 32'h0, 0, 0, 1);
      step = 1; edge_step(); step = 0;
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL bubble_en: got %b want 0", wb_en); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", o_valid); end
      checks++; if (retired !== r0 + 1) begin errors++; $display("FAIL bubble_retired: got %0d want %0d", retired, r0 + 1); end
      checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL bubble_halt: got %b want 0", o_halt); end
   endtask

   task automatic test_stall();
      logic [NB-1:0] r0;
      set_instr(1, 1, 5'd3, 32'hCAFE0003, 32'h0, 32'h0, 0, 0, 0);
      step = 1; edge_step(); step = 0;
      r0 = retired;
      for (int c = 0; c < 5; c++) begin
         checks++; if (wb_addr !== 5'd3) begin errors++; $display("FAIL stall_addr[%0d]: got %0d want 3", c, wb_addr); end
         checks++; if (wb_data !== 32'hCAFE0003) begin errors++; $display("FAIL stall_data[%0d]: got %h want cafe0003", c, wb_data); end
         checks++; if (wb_en !== (c == 0)) begin errors++; $display("FAIL stall_en[%0d]: got %b want %b", c, wb_en, c == 0); end
         checks++; if (retired !== r0) begin errors++; $display("FAIL stall_retired[%0d]: got %0d want %0d", c, retired, r0); end
         if (c < 4) begin
            set_instr(1, 1, 5'($urandom_range(1, 31)), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1);
            edge_step();
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         step = (c < 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
         set_instr(($urandom_range(0, 7) != 0), 1'($urandom),
                   ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                   $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 0);
         edge_step();
         checks++; if (wb_en !== m_we) begin errors++; $display("FAIL rand_en[%0d]: got %b want %b", c, wb_en, m_we); end
         checks++; if (o_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", c, o_valid, m_valid); end
         checks++; if (retired !== m_ret) begin errors++; $display("FAIL rand_retired[%0d]: got %0d want %0d", c, retired, m_ret); end
         if (m_valid) begin
            checks++; if (wb_data !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", c, wb_data, m_data); end
            checks++; if (wb_addr !== m_rd) begin errors++; $display("FAIL rand_addr[%0d]: got %0d want %0d", c, wb_addr, m_rd); end
         end
      end
      step = 0;
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         set_instr(1, 1, 5'(i), 32'(i * 16), 32'h0, 32'h0, 0, 0, 0);
         step = 1; edge_step();
      end
      set_instr(1, 1, 5'd4, 32'h99, 32'h0, 32'h0, 0, 0, 1);
      edge_step();
      checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b want 1", o_halt); end
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL halt_en: got %b want 0", wb_en); end
      checks++; if (retired !== 32'd4) begin errors++; $display("FAIL halt_retired: got %0d want 4", retired); end
      for (int i = 0; i < 3; i++) begin
         set_instr(1, 1, 5'd20 + 5'(i), 32'h77, 32'h0, 32'h0, 0, 0, 0);
         edge_step();
         checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL halted_en[%0d]: got %b want 0", i, wb_en); end
         checks++; if (retired !== 32'd4) begin errors++; $display("FAIL halted_retired[%0d]: got %0d want 4", i, retired); end
         checks++; if (wb_addr !== 5'd4) begin errors++; $display("FAIL halted_addr[%0d]: got %0d want 4", i, wb_addr); end
         checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL halted_flag[%0d]: got %b want 1", i, o_halt); end
      end
      step = 0;
   endtask

   task automatic test_reset_mid();
      rst_n = 0; step = 1;
      set_instr(1, 1, 5'd8, 32'h8888, 32'h0, 32'h0, 0, 0, 0);
      edge_step();
      rst_n = 1; step = 0;
      checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL rmid_halt: got %b want 0", o_halt); end
      checks++; if (retired !== '0) begin errors++; $display("FAIL rmid_retired: got %0d want 0", retired); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", o_valid); end
      checks++; if (wb_data !== '0) begin errors++; $display("FAIL rmid_data: got %h want 0", wb_data); end
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rmid_en: got %b want 0", wb_en); end
      // Mid-stream: an instruction due to write is discarded by reset.
      set_instr(1, 1, 5'd12, 32'h1200, 32'h0, 32'h0, 0, 0, 0);
      step = 1; edge_step();
      rst_n = 0; step = 1;
      set_instr(1, 1, 5'd13, 32'h1300, 32'h0, 32'h0, 0, 0, 0);
      edge_step();
      rst_n = 1; step = 0;
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rstream_en0: got %b want 0", wb_en); end
      checks++; if (wb_addr !== 5'd0) begin errors++; $display("FAIL rstream_addr: got %0d want 0", wb_addr); end
      edge_step();
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rstream_en1: got %b want 0", wb_en); end
      set_instr(1, 1, 5'd7, 32'hBEEF, 32'h0, 32'h0, 0, 0, 0);
      step = 1; edge_step(); step = 0;
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL rpost_en: got %b want 1", wb_en); end
      checks++; if (wb_data !== 32'hBEEF) begin errors++; $display("FAIL rpost_data: got %h want 0000beef", wb_data); end
      checks++; if (wb_addr !== 5'd7) begin errors++; $display("FAIL rpost_addr: got %0d want 7", wb_addr); end
      checks++; if (retired !== 32'd1) begin errors++; $display("FAIL rpost_retired: got %0d want 1", retired); end
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_priority();
      test_zero_bubble();
      test_stall();
      test_random();
      test_halt();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back select for the MIPS pipeline.
- Sits directly downstream of the memory stage: captures the adapted load data and the ALU result forwarded through MEM, and produces the register-file write port.
- Tracks halt retirement and counts retired instructions for the debug unit.
- All state advances only on i_step.

Parameters:
NB, 32, data/address width
NB_REG, 5, register-file address width

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous reset, active-low
i_step  input  1  pipeline advance enable (debug step / run)
i_valid  input  1  instruction present in MEM stage
i_data_memory  input  NB  load data from memory stage (already size/sign adapted)
i_alu_result  input  NB  ALU result carried through MEM
i_pc_link  input  NB  return address for link instructions (jal/jalr)
i_rd_addr  input  NB_REG  destination register
i_reg_write  input  1  instruction writes register file
i_mem_to_reg  input  1  select load data for write-back
i_link  input  1  select i_pc_link for write-back
i_halt  input  1  instruction is HALT
o_wb_data  output  NB  register-file write data
o_wb_addr  output  NB_REG  register-file write address
o_wb_enable  output  1  register-file write strobe
o_valid  output  1  WB stage holds a valid instruction
o_halt  output  1  HALT has retired; pipeline finished
o_retired  output  NB  retired-instruction count

Behaviour:
- Clocking: single clock, rising edge. Reset is synchronous and active-low (i_reset==0 at the edge), with priority over everything.
- Reset values:
  - o_wb_data=0, o_wb_addr=0, o_wb_enable=0, o_valid=0, o_halt=0, o_retired=0.
  - State=RUN.
- State machine: RUN, HALTED.
  - RUN, i_step=1: latch all inputs into the WB register (valid, data, alu, link, rd, control bits).
  - RUN, i_step=0: register holds; o_wb_enable forced 0 that cycle, so a stalled instruction never writes twice.
  - RUN -> HALTED: on the step edge that latches i_valid=1 and i_halt=1. o_halt=1 from the next cycle.
  - HALTED: register frozen, i_step ignored, o_wb_enable=0, o_retired frozen. Exits only via reset.
- Latency: one step edge. Values presented with i_step=1 at edge N appear on outputs after edge N.
- Write-back mux, on latched values, priority: link > mem_to_reg > alu.
  - o_wb_data = link ? pc_link : (mem_to_reg ? data_memory : alu_result).
  - o_wb_data is combinational from the latch.
- o_wb_enable = latched_valid & latched_reg_write & (latched_rd != 0) & ~latched_halt & step_d.
  - step_d is 1 for exactly the cycle after a step edge.
  - Writes to $0 are suppressed; o_wb_addr still shows 0.
- o_valid = latched valid bit.
- A bubble (i_valid=0) latches with all control bits ignored and causes no write.
- o_retired:
  - +1 on each step edge that latches i_valid=1, HALT included.
  - Saturates at 2^NB-1, no wrap.
  - Counts in RUN only.
- Simultaneous events:
  - Reset with step: reset wins.
  - HALT arriving with reg_write=1: no write.
  - Step held high continuously: one instruction per cycle, one write per instruction.
- Reset mid-operation: discards the latched instruction; no write is issued in the reset cycle or the cycle after.

Test Plan:
1. ALU write: i_valid=1, i_reg_write=1, rd=5, alu=0x1234, mem_to_reg=0, link=0, step pulse -> next cycle o_wb_addr=5, o_wb_data=0x1234, o_wb_enable=1 for exactly 1 cycle, o_retired=1.
2. Load and link priority:
   - mem_to_reg=1, data_memory=0xFFFFFF80, alu=0x10 -> o_wb_data=0xFFFFFF80.
   - Then link=1, mem_to_reg=1, pc_link=0x48 -> o_wb_data=0x48.
3. $0 and bubble:
   - rd=0, reg_write=1, valid=1 -> o_wb_enable=0, o_retired increments.
   - valid=0, reg_write=1 -> o_wb_enable=0, o_valid=0, o_retired unchanged.
4. Stall: latch rd=3, then hold i_step=0 for 4 cycles while changing inputs -> outputs unchanged, o_wb_enable high only in the first cycle after the step.
5. Halt: three valid instructions, then valid=1, halt=1, reg_write=1 -> o_halt=1, no write, o_retired=4. Further steps with valid instructions change nothing.
6. Reset: assert i_reset=0 one cycle while o_halt=1 and mid-stream -> all outputs 0, state RUN. The next step with valid ALU instruction writes normally.
